// File: rtl/sim_ctrl_pkg.sv
// Shared types for the simulation run-control sequencer.
//   state_e           : run-control FSM states
//   status_e          : encoding reported on the sequencer's status output
//   CNT_WIDTH_DEFAULT : default width of cycle counters and thresholds
package sim_ctrl_pkg;

    localparam int CNT_WIDTH_DEFAULT = 64;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        HOLD = 3'd1,
        RUN  = 3'd2,
        PASS = 3'd3,
        FAIL = 3'd4
    } state_e;

    typedef enum logic [1:0] {
        STATUS_RUNNING       = 2'd0,
        STATUS_PASS          = 2'd1,
        STATUS_WATCHDOG_FAIL = 2'd2,
        STATUS_GLOBAL_FAIL   = 2'd3
    } status_e;

endpackage

// File: rtl/sim_sat_counter.sv
// Saturating up-counter with synchronous clear and count enable.
//   clock    : clock
//   reset    : synchronous active-high reset (clears the count)
//   clr      : synchronous clear, takes priority over en
//   en       : load cnt_next on this edge
//   cnt      : current count
//   cnt_next : cnt + 1, held at all-ones once saturated
module sim_sat_counter #(
    parameter int WIDTH = 64
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             clr,
    input  logic             en,
    output logic [WIDTH-1:0] cnt,
    output logic [WIDTH-1:0] cnt_next
);

    assign cnt_next = (&cnt) ? cnt : cnt + WIDTH'(1);

    always_ff @(posedge clock) begin
        if (reset || clr) begin
            cnt <= '0;
        end else if (en) begin
            cnt <= cnt_next;
        end
    end

endmodule

// File: rtl/sim_control_sequencer.sv
// Run-control sequencer for the emulation top: holds the DUT in reset after
// configuration, counts RUN cycles, runs the inter-retire watchdog and the
// global timeout, gates the waveform dump window and reports one status.
//   clock, reset        : clock, synchronous active-high reset
//   cfg_valid           : capture cfg_* (IDLE only)
//   cfg_timeout         : max cycles between retires, 0 = off
//   cfg_global_timeout  : max RUN cycles, 0 = off
//   cfg_dump_start/end  : RUN cycle window for dump_on (end 0 = never off)
//   retire_valid        : retire pulse from the DUT
//   dpi_done, tb_done   : completion levels, both high = PASS
//   dut_reset           : reset to the DUT
//   dump_on             : waveform dump enable
//   status/status_valid : 0 running, 1 pass, 2 watchdog, 3 global; valid when terminal
//   cycle               : completed RUN cycles, saturating
//
// state | meaning
// IDLE  | waiting for cfg_valid, DUT held in reset
// HOLD  | config captured, DUT reset held for RESET_CYCLES cycles
// RUN   | DUT running, counters and termination checks active
// PASS  | dpi_done && tb_done seen, sticky until reset
// FAIL  | watchdog or global timeout fired, sticky until reset
module sim_control_sequencer
    import sim_ctrl_pkg::*;
#(
    parameter int CNT_WIDTH    = CNT_WIDTH_DEFAULT,
    parameter int RESET_CYCLES = 4
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 cfg_valid,
    input  logic [CNT_WIDTH-1:0] cfg_timeout,
    input  logic [CNT_WIDTH-1:0] cfg_global_timeout,
    input  logic [CNT_WIDTH-1:0] cfg_dump_start,
    input  logic [CNT_WIDTH-1:0] cfg_dump_end,
    input  logic                 retire_valid,
    input  logic                 dpi_done,
    input  logic                 tb_done,
    output logic                 dut_reset,
    output logic                 dump_on,
    output logic [1:0]           status,
    output logic                 status_valid,
    output logic [CNT_WIDTH-1:0] cycle
);

    state_e                 state_q, state_d;
    status_e                status_q, status_d;
    logic                   dump_q, dump_d;
    logic                   dump_done_q, dump_done_d;
    logic                   cfg_load;

    logic [CNT_WIDTH-1:0]   timeout_q, global_timeout_q, dump_start_q, dump_end_q;

    logic [CNT_WIDTH-1:0]   cycle_next;
    logic [CNT_WIDTH-1:0]   idle_cnt, idle_next, idle_n;
    logic [CNT_WIDTH-1:0]   hold_cnt, hold_next;

    logic                   in_run, hold_done, run_entry;
    logic                   wd_trip, gl_trip, dump_set, dump_clr;

    assign in_run    = (state_q == RUN);
    assign hold_done = (hold_cnt == CNT_WIDTH'(RESET_CYCLES - 1));
    assign run_entry = (state_q == HOLD) && hold_done;

    sim_sat_counter #(.WIDTH(CNT_WIDTH)) u_cycle_cnt (
        .clock    (clock),
        .reset    (reset),
        .clr      (run_entry),
        .en       (in_run),
        .cnt      (cycle),
        .cnt_next (cycle_next)
    );

    // A retire on the current edge restarts the idle count, so idle_n is
    // what the idle counter holds after this edge.
    sim_sat_counter #(.WIDTH(CNT_WIDTH)) u_idle_cnt (
        .clock    (clock),
        .reset    (reset),
        .clr      (run_entry || (in_run && retire_valid)),
        .en       (in_run),
        .cnt      (idle_cnt),
        .cnt_next (idle_next)
    );

    assign idle_n = retire_valid ? '0 : idle_next;

    sim_sat_counter #(.WIDTH(CNT_WIDTH)) u_hold_cnt (
        .clock    (clock),
        .reset    (reset),
        .clr      ((state_q == IDLE) && cfg_valid),
        .en       (state_q == HOLD),
        .cnt      (hold_cnt),
        .cnt_next (hold_next)
    );

    // Each counter is consumed through only one of its two views.
    logic unused_cnt_views;
    assign unused_cnt_views = ^{idle_cnt, hold_next};

    assign wd_trip  = (timeout_q != '0) && (idle_n == timeout_q);
    assign gl_trip  = (global_timeout_q != '0) && (cycle_next == global_timeout_q);
    assign dump_set = (dump_start_q != '0) && (cycle_next == dump_start_q);
    assign dump_clr = (dump_end_q != '0) && (cycle_next == dump_end_q);

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q          <= IDLE;
            status_q         <= STATUS_RUNNING;
            dump_q           <= 1'b0;
            dump_done_q      <= 1'b0;
            timeout_q        <= '0;
            global_timeout_q <= '0;
            dump_start_q     <= '0;
            dump_end_q       <= '0;
        end else begin
            state_q     <= state_d;
            status_q    <= status_d;
            dump_q      <= dump_d;
            dump_done_q <= dump_done_d;
            if (cfg_load) begin
                timeout_q        <= cfg_timeout;
                global_timeout_q <= cfg_global_timeout;
                dump_start_q     <= cfg_dump_start;
                dump_end_q       <= cfg_dump_end;
            end
        end
    end

    always_comb begin
        state_d     = state_q;
        status_d    = status_q;
        dump_d      = dump_q;
        dump_done_d = dump_done_q;
        cfg_load    = 1'b0;

        case (state_q)
            IDLE: begin
                if (cfg_valid) begin
                    cfg_load    = 1'b1;
                    dump_done_d = 1'b0;
                    state_d     = HOLD;
                end
            end
            HOLD: begin
                if (hold_done) begin
                    state_d = RUN;
                    if (dump_start_q == '0) begin
                        dump_d = 1'b1;
                    end
                end
            end
            RUN: begin
                // Clear beats set on the same edge and disarms the window
                // for the rest of the run.
                if (dump_clr) begin
                    dump_d      = 1'b0;
                    dump_done_d = 1'b1;
                end else if (dump_set && !dump_done_q) begin
                    dump_d = 1'b1;
                end

                if (dpi_done && tb_done) begin
                    state_d  = PASS;
                    status_d = STATUS_PASS;
                    dump_d   = 1'b0;
                end else if (wd_trip) begin
                    state_d  = FAIL;
                    status_d = STATUS_WATCHDOG_FAIL;
                    dump_d   = 1'b0;
                end else if (gl_trip) begin
                    state_d  = FAIL;
                    status_d = STATUS_GLOBAL_FAIL;
                    dump_d   = 1'b0;
                end
            end
            default: ;
        endcase
    end

    assign dut_reset    = (state_q == IDLE) || (state_q == HOLD);
    assign status_valid = (state_q == PASS) || (state_q == FAIL);
    assign status       = status_q;
    assign dump_on      = dump_q;

endmodule
